// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/response bundle between the issue stage and alu_exec_unit
interface alu_exec_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Flush;
  logic                  Valid_In;
  logic                  Ready_Out;
  logic [2:0]            ALU_Ctrl;
  logic                  Sub;
  logic                  Funct7_5;
  logic                  Imm_Op;
  logic [2:0]            Funct3;
  logic [DATA_WIDTH-1:0] Op_A;
  logic [DATA_WIDTH-1:0] Op_B;
  logic                  Valid_Out;
  logic                  Ready_In;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Zero;
  logic                  Branch_Taken;
  logic                  Illegal_Op;

  modport slave (
    input  Flush, Valid_In, ALU_Ctrl, Sub, Funct7_5, Imm_Op, Funct3, Op_A, Op_B, Ready_In,
    output Ready_Out, Valid_Out, Result, Zero, Branch_Taken, Illegal_Op
  );

  modport master (
    output Flush, Valid_In, ALU_Ctrl, Sub, Funct7_5, Imm_Op, Funct3, Op_A, Op_B, Ready_In,
    input  Ready_Out, Valid_Out, Result, Zero, Branch_Taken, Illegal_Op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-issue ALU with bit-serial shifter and valid/ready result handshake
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic           CLK,
  input logic           RST,
  alu_exec_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  br_q, br_d;
  logic                  ill_q, ill_d;
  logic                  left_q, left_d;
  logic                  arith_q, arith_d;

  logic [DATA_WIDTH-1:0] diff, logic_res, alu_res;
  logic                  lt_s, lt_u, slt_bit, logic_ill, br_cond, is_shift, sh_ill, illegal, taken;
  logic [4:0]            amt;

  assign diff    = bus.Op_A - bus.Op_B;
  assign lt_s    = $signed(bus.Op_A) < $signed(bus.Op_B);
  assign lt_u    = bus.Op_A < bus.Op_B;
  assign slt_bit = bus.Funct3[0] ? lt_u : lt_s;
  assign amt     = bus.Op_B[4:0];
  assign sh_ill  = (bus.Funct3 != 3'b001) && (bus.Funct3 != 3'b101);

  always_comb begin
    logic_res = '0;
    logic_ill = 1'b0;
    case (bus.Funct3)
      3'b100:  logic_res = bus.Op_A ^ bus.Op_B;
      3'b110:  logic_res = bus.Op_A | bus.Op_B;
      3'b111:  logic_res = bus.Op_A & bus.Op_B;
      default: logic_ill = 1'b1;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (bus.Funct3)
      3'b000:  br_cond = (bus.Op_A == bus.Op_B);
      3'b001:  br_cond = (bus.Op_A != bus.Op_B);
      3'b100:  br_cond = lt_s;
      3'b101:  br_cond = !lt_s;
      3'b110:  br_cond = lt_u;
      3'b111:  br_cond = !lt_u;
      default: br_cond = 1'b0;
    endcase
  end

  // Shift ops report Op_A here; a zero amount completes directly with it.
  always_comb begin
    alu_res  = '0;
    illegal  = 1'b0;
    taken    = 1'b0;
    is_shift = 1'b0;
    case (bus.ALU_Ctrl)
      3'b000: alu_res = bus.Sub ? diff : bus.Op_A + bus.Op_B;
      3'b001: alu_res = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
      3'b010: begin alu_res = logic_res; illegal = logic_ill; end
      3'b011: begin
        if (bus.Imm_Op) begin
          alu_res = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
        end else begin
          alu_res  = bus.Op_A;
          illegal  = sh_ill;
          is_shift = !sh_ill;
        end
      end
      3'b100: begin
        if (bus.Imm_Op) begin
          alu_res = logic_res;
          illegal = logic_ill;
        end else begin
          alu_res = diff;
          illegal = (bus.Funct3 == 3'b010) || (bus.Funct3 == 3'b011);
          taken   = br_cond;
        end
      end
      3'b101: begin
        alu_res  = bus.Op_A;
        illegal  = sh_ill;
        is_shift = !sh_ill;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_res = '0;
      taken   = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    br_d     = br_q;
    ill_d    = ill_q;
    left_d   = left_q;
    arith_d  = arith_q;
    if (bus.Flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Valid_In) begin
            result_d = alu_res;
            br_d     = taken;
            ill_d    = illegal;
            left_d   = (bus.Funct3 == 3'b001);
            arith_d  = bus.Funct7_5;
            if (is_shift && amt != 5'd0) begin
              cnt_d   = amt;
              state_d = SHIFT;
            end else begin
              state_d = DONE;
            end
          end
        end
        SHIFT: begin
          if (left_q)       result_d = result_q << 1;
          else if (arith_q) result_d = {result_q[DATA_WIDTH-1], result_q[DATA_WIDTH-1:1]};
          else              result_d = result_q >> 1;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = DONE;
        end
        DONE: begin
          if (bus.Ready_In) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      br_q     <= br_d;
      ill_q    <= ill_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
    end
  end

  assign bus.Ready_Out    = (state_q == IDLE);
  assign bus.Valid_Out    = (state_q == DONE);
  assign bus.Result       = result_q;
  assign bus.Zero         = (result_q == '0);
  assign bus.Branch_Taken = br_q;
  assign bus.Illegal_Op   = ill_q;
endmodule
